// File: rtl/stage_memory_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Request is held until a one-cycle ready; rdata is valid together with ready.
interface stage_memory_if;
  logic        out_mem_req;
  logic        out_mem_we;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_wdata;
  logic [3:0]  out_mem_wstrb;
  logic        in_mem_ready;
  logic [31:0] in_mem_rdata;

  modport master (
    output out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_wstrb,
    input  in_mem_ready, in_mem_rdata
  );
  modport slave (
    input  out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_wstrb,
    output in_mem_ready, in_mem_rdata
  );
endinterface

// File: rtl/stage_memory.sv
// Pipeline memory stage: aligned loads/stores over a request/ready bus with stall,
// load extension, and one-cycle exceptions for misalignment and bus timeout.
module stage_memory #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_alu_out,
  input  logic [31:0] in_mem_in_data,
  input  logic [2:0]  in_funct3,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [4:0]  in_rd,
  input  logic        in_mem_to_reg,
  input  logic        in_write_enable,
  stage_memory_if.master mem,
  output logic        out_stall,
  output logic [31:0] out_read_data,
  output logic [31:0] out_alu_out,
  output logic [4:0]  out_rd,
  output logic        out_mem_to_reg,
  output logic        out_write_enable,
  output logic        out_exception,
  output logic [1:0]  out_exc_cause
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    wstrb_q;
  logic          we_q, tmo_q;
  logic [2:0]    funct3_q;
  logic [1:0]    lane_q;
  logic [CW-1:0] cnt;

  logic        access, misaligned, timeout_hit, start;
  logic [31:0] wdata_lane, rdata_shift, rdata_ext;
  logic [3:0]  wstrb_lane;

  assign access     = in_mem_read | in_mem_write;
  assign misaligned = ((in_funct3[1:0] == 2'b01) && in_alu_out[0]) ||
                      ((in_funct3[1:0] == 2'b10) && (in_alu_out[1:0] != 2'b00));
  // Counter holds (BUSY cycles - 1), so this fires in the TIMEOUT-th BUSY cycle.
  assign timeout_hit = (TIMEOUT != 0) && ((cnt + CW'(1)) == TO_LAST);

  // Store data replicated to every lane; strobes select the lanes actually written.
  always_comb begin
    wdata_lane = in_mem_in_data;
    wstrb_lane = 4'b1111;
    case (in_funct3[1:0])
      2'b00: begin
        wdata_lane = {4{in_mem_in_data[7:0]}};
        wstrb_lane = 4'b0001 << in_alu_out[1:0];
      end
      2'b01: begin
        wdata_lane = {2{in_mem_in_data[15:0]}};
        wstrb_lane = in_alu_out[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!in_mem_write) wstrb_lane = 4'b0000;
  end

  always_comb begin
    rdata_shift = mem.in_mem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  rdata_ext = {{24{rdata_shift[7]}},  rdata_shift[7:0]};
      3'b001:  rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  rdata_ext = {24'b0, rdata_shift[7:0]};
      3'b101:  rdata_ext = {16'b0, rdata_shift[15:0]};
      default: rdata_ext = rdata_shift;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    out_stall     = 1'b0;
    out_exception = 1'b0;
    out_exc_cause = 2'b00;
    start         = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            out_exception = 1'b1;
            out_exc_cause = in_mem_read ? 2'b01 : 2'b10;
          end else begin
            out_stall = 1'b1;
            start     = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        out_stall = 1'b1;
        if (mem.in_mem_ready || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        out_exception = tmo_q;
        out_exc_cause = tmo_q ? 2'b11 : 2'b00;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      lane_q   <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      tmo_q    <= 1'b0;
    end else if (start) begin
      addr_q   <= {in_alu_out[31:2], 2'b00};
      wdata_q  <= wdata_lane;
      wstrb_q  <= wstrb_lane;
      we_q     <= in_mem_write;
      funct3_q <= in_funct3;
      lane_q   <= in_alu_out[1:0];
      cnt      <= '0;
      rdata_q  <= '0;
      tmo_q    <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      // Ready has priority over a coincident timeout.
      if (mem.in_mem_ready) begin
        if (!we_q) rdata_q <= rdata_ext;
      end else if (timeout_hit) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign mem.out_mem_req   = (state == BUSY);
  assign mem.out_mem_we    = we_q;
  assign mem.out_mem_addr  = addr_q;
  assign mem.out_mem_wdata = wdata_q;
  assign mem.out_mem_wstrb = wstrb_q;

  assign out_read_data    = (state == DONE) ? rdata_q : 32'h0;
  assign out_alu_out      = in_alu_out;
  assign out_rd           = in_rd;
  assign out_mem_to_reg   = in_mem_to_reg;
  assign out_write_enable = in_write_enable & ~out_exception;

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed vector table, reset corner cases, and randomized
// accesses checked against a spec-level reference model.
module tb_stage_memory;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_alu_out, in_mem_in_data;
  logic [2:0]  in_funct3;
  logic        in_mem_read, in_mem_write, in_mem_to_reg, in_write_enable;
  logic [4:0]  in_rd;
  logic        out_stall, out_mem_to_reg, out_write_enable, out_exception;
  logic [31:0] out_read_data, out_alu_out;
  logic [4:0]  out_rd;
  logic [1:0]  out_exc_cause;

  stage_memory_if bus();

  stage_memory #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .in_alu_out(in_alu_out), .in_mem_in_data(in_mem_in_data), .in_funct3(in_funct3),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_rd(in_rd),
    .in_mem_to_reg(in_mem_to_reg), .in_write_enable(in_write_enable),
    .mem(bus),
    .out_stall(out_stall), .out_read_data(out_read_data), .out_alu_out(out_alu_out),
    .out_rd(out_rd), .out_mem_to_reg(out_mem_to_reg), .out_write_enable(out_write_enable),
    .out_exception(out_exception), .out_exc_cause(out_exc_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;       // BUSY cycle in which ready is given, 0 = never
    int          e_stall;
    int          e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_exc;
    logic [1:0]  e_cause;
  } vec_t;

  typedef struct {
    int          stall;
    int          req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
    logic [31:0] rdata;
    logic        exc;
    logic [1:0]  cause;
    logic        wen;
    logic [4:0]  prd;
    logic [31:0] palu;
  } obs_t;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: what the spec says an access should do, from sizes and byte arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    int sz, k;
    logic [31:0] mask, w;
    e = v;
    sz = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
    e.e_stall = 0; e.e_req = 0; e.e_addr = {v.addr[31:2], 2'b00};
    e.e_wstrb = 4'h0; e.e_wdata = 32'h0; e.e_rdata = 32'h0; e.e_exc = 1'b0; e.e_cause = 2'b00;
    if (!(v.rd || v.wr)) return e;
    if ((v.addr % sz) != 0) begin
      e.e_exc = 1'b1;
      e.e_cause = v.rd ? 2'b01 : 2'b10;
      return e;
    end
    k = (v.k >= 1 && v.k <= TMO) ? v.k : TMO;
    e.e_req = k;
    e.e_stall = k + 1;
    if (v.wr) begin
      e.e_wstrb = 4'(((1 << sz) - 1) << v.addr[1:0]);
      e.e_wdata = (sz == 1) ? 32'h01010101 * v.wdata[7:0] :
                  (sz == 2) ? 32'h00010001 * v.wdata[15:0] : v.wdata;
    end
    if (k == v.k) begin
      if (v.rd) begin
        mask = (sz == 4) ? 32'hFFFFFFFF : 32'((1 << (8 * sz)) - 1);
        w = (v.rdata >> (8 * v.addr[1:0])) & mask;
        if (!v.f3[2] && sz < 4 && w[8 * sz - 1]) w = w | ~mask;
        e.e_rdata = w;
      end
    end else begin
      e.e_exc = 1'b1;
      e.e_cause = 2'b11;
    end
    return e;
  endfunction

  task automatic run(input vec_t v, output obs_t o);
    int busy;
    bit fin;
    o = '{default: 0};
    busy = 0;
    fin = 1'b0;
    @(posedge clk); #1;
    in_alu_out = v.addr; in_mem_in_data = v.wdata; in_funct3 = v.f3;
    in_mem_read = v.rd; in_mem_write = v.wr; in_rd = v.addr[6:2];
    in_mem_to_reg = v.rd; in_write_enable = !v.wr;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      bus.in_mem_ready = 1'b0;
      bus.in_mem_rdata = $urandom;
      if (bus.out_mem_req) begin
        busy++;
        o.req++;
        if (busy == 1) begin
          o.addr = bus.out_mem_addr; o.wdata = bus.out_mem_wdata;
          o.wstrb = bus.out_mem_wstrb; o.we = bus.out_mem_we;
        end
        if (busy == v.k) begin
          bus.in_mem_ready = 1'b1;
          bus.in_mem_rdata = v.rdata;
        end
      end
      if (out_stall) o.stall++;
      else begin
        fin = 1'b1;
        o.rdata = out_read_data; o.exc = out_exception; o.cause = out_exc_cause;
        o.wen = out_write_enable; o.prd = out_rd; o.palu = out_alu_out;
      end
    end
    if (!fin) begin
      n_cmp++; n_fail++;
      $display("FAIL access_bound: stall never released within 20 cycles");
    end
  endtask

  task automatic check(input string nm, input vec_t v, input vec_t e, input obs_t o);
    chk({nm, ".stall"}, o.stall, e.e_stall);
    chk({nm, ".req"},   o.req,   e.e_req);
    chk({nm, ".rdata"}, o.rdata, e.e_rdata);
    chk({nm, ".exc"},   {31'b0, o.exc}, {31'b0, e.e_exc});
    chk({nm, ".cause"}, {30'b0, o.cause}, {30'b0, e.e_cause});
    chk({nm, ".wen"},   {31'b0, o.wen}, {31'b0, !v.wr && !e.e_exc});
    chk({nm, ".rd"},    {27'b0, o.prd}, {27'b0, v.addr[6:2]});
    chk({nm, ".alu"},   o.palu, v.addr);
    if (e.e_req > 0) begin
      chk({nm, ".addr"},  o.addr, e.e_addr);
      chk({nm, ".wstrb"}, {28'b0, o.wstrb}, {28'b0, e.e_wstrb});
      chk({nm, ".we"},    {31'b0, o.we}, {31'b0, v.wr});
      if (v.wr) chk({nm, ".wdata"}, o.wdata, e.e_wdata);
    end
  endtask

  vec_t tbl[15];
  vec_t v, e;
  obs_t o;

  initial begin
    tbl[0]  = '{3'b010, 1, 0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 2, 1, 32'h100, 4'h0, 32'h0,        32'hDEADBEEF, 0, 2'd0};
    tbl[1]  = '{3'b000, 1, 0, 32'h103, 32'h0,        32'h80FF0000, 1, 2, 1, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80, 0, 2'd0};
    tbl[2]  = '{3'b100, 1, 0, 32'h103, 32'h0,        32'h80FF0000, 1, 2, 1, 32'h100, 4'h0, 32'h0,        32'h00000080, 0, 2'd0};
    tbl[3]  = '{3'b101, 1, 0, 32'h102, 32'h0,        32'h80FF0000, 1, 2, 1, 32'h100, 4'h0, 32'h0,        32'h000080FF, 0, 2'd0};
    tbl[4]  = '{3'b001, 1, 0, 32'h102, 32'h0,        32'h80FF0000, 1, 2, 1, 32'h100, 4'h0, 32'h0,        32'hFFFF80FF, 0, 2'd0};
    tbl[5]  = '{3'b000, 0, 1, 32'h201, 32'h000000AB, 32'h0,        2, 3, 2, 32'h200, 4'h2, 32'hABABABAB, 32'h0,        0, 2'd0};
    tbl[6]  = '{3'b001, 0, 1, 32'h202, 32'h00001234, 32'h0,        1, 2, 1, 32'h200, 4'hC, 32'h12341234, 32'h0,        0, 2'd0};
    tbl[7]  = '{3'b010, 0, 1, 32'h30C, 32'hCAFEF00D, 32'h0,        3, 4, 3, 32'h30C, 4'hF, 32'hCAFEF00D, 32'h0,        0, 2'd0};
    tbl[8]  = '{3'b010, 1, 0, 32'h102, 32'h0,        32'h0,        1, 0, 0, 32'h100, 4'h0, 32'h0,        32'h0,        1, 2'd1};
    tbl[9]  = '{3'b001, 0, 1, 32'h301, 32'h1234,     32'h0,        1, 0, 0, 32'h300, 4'h0, 32'h0,        32'h0,        1, 2'd2};
    tbl[10] = '{3'b010, 1, 0, 32'h040, 32'h0,        32'h11111111, 0, 5, 4, 32'h040, 4'h0, 32'h0,        32'h0,        1, 2'd3};
    tbl[11] = '{3'b010, 1, 0, 32'h044, 32'h0,        32'h12345678, 4, 5, 4, 32'h044, 4'h0, 32'h0,        32'h12345678, 0, 2'd0};
    tbl[12] = '{3'b010, 0, 0, 32'h102, 32'h0,        32'h0,        1, 0, 0, 32'h100, 4'h0, 32'h0,        32'h0,        0, 2'd0};
    tbl[13] = '{3'b000, 1, 0, 32'h101, 32'h0,        32'h00007F00, 1, 2, 1, 32'h100, 4'h0, 32'h0,        32'h0000007F, 0, 2'd0};
    tbl[14] = '{3'b010, 1, 0, 32'h048, 32'h0,        32'h55555555, 5, 5, 4, 32'h048, 4'h0, 32'h0,        32'h0,        1, 2'd3};

    reset = 1'b1;
    in_alu_out = 32'h0; in_mem_in_data = 32'h0; in_funct3 = 3'b0;
    in_mem_read = 1'b0; in_mem_write = 1'b0; in_rd = 5'h0;
    in_mem_to_reg = 1'b0; in_write_enable = 1'b0;
    bus.in_mem_ready = 1'b0; bus.in_mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst.req",   {31'b0, bus.out_mem_req}, 32'h0);
    chk("rst.we",    {31'b0, bus.out_mem_we}, 32'h0);
    chk("rst.wstrb", {28'b0, bus.out_mem_wstrb}, 32'h0);
    chk("rst.addr",  bus.out_mem_addr, 32'h0);
    chk("rst.wdata", bus.out_mem_wdata, 32'h0);
    chk("rst.rdata", out_read_data, 32'h0);
    chk("rst.exc",   {31'b0, out_exception}, 32'h0);
    chk("rst.cause", {30'b0, out_exc_cause}, 32'h0);
    chk("rst.stall", {31'b0, out_stall}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run(tbl[i], o);
      check($sformatf("vec%0d", i), tbl[i], tbl[i], o);
    end

    // Reset while the bus request is outstanding.
    @(posedge clk); #1;
    in_alu_out = 32'h100; in_funct3 = 3'b010; in_mem_read = 1'b1; in_mem_write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst.req_before", {31'b0, bus.out_mem_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.req_after", {31'b0, bus.out_mem_req}, 32'h0);
    chk("midrst.addr",      bus.out_mem_addr, 32'h0);
    chk("midrst.rdata",     out_read_data, 32'h0);
    in_mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    v = tbl[0];
    v.rdata = 32'h0BADF00D;
    run(v, o);
    check("after_rst", v, model(v), o);

    for (int i = 0; i < 300; i++) begin
      v = '{default: 0};
      case ($urandom_range(0, 7))
        0:       begin v.rd = 1'b0; v.wr = 1'b0; v.f3 = 3'($urandom); end
        1, 2, 3: begin v.wr = 1'b1; v.f3 = 3'($urandom_range(0, 2)); end
        default: begin
          v.rd = 1'b1;
          case ($urandom_range(0, 4))
            0: v.f3 = 3'b000; 1: v.f3 = 3'b001; 2: v.f3 = 3'b010;
            3: v.f3 = 3'b100; default: v.f3 = 3'b101;
          endcase
        end
      endcase
      v.addr = $urandom;
      if ($urandom_range(0, 3) != 0)
        v.addr = (v.f3[1:0] == 2'b10) ? {v.addr[31:2], 2'b00} :
                 (v.f3[1:0] == 2'b01) ? {v.addr[31:1], 1'b0} : v.addr;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.k = $urandom_range(0, 6);
      e = model(v);
      run(v, o);
      check($sformatf("rnd%0d", i), v, e, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_memory.md
# stage_memory

Memory stage of the five-stage pipeline. It takes the EX/MEM register contents (ALU result as address, forwarded store data, funct3, control bits) and performs loads and stores on a single-ported data-memory bus with a request/ready handshake, stalling the pipeline until the access completes. It produces load data that is aligned and sign- or zero-extended for MEM/WB. Misaligned accesses and bus timeouts are reported as a one-cycle exception instead of being performed.

## Interface
- TIMEOUT, 255: maximum cycles to wait for `in_mem_ready`; 0 disables the timeout.

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- in_alu_out  input  32  effective address / ALU result from EX/MEM
- in_mem_in_data  input  32  store data (already forwarded)
- in_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_mem_read, in_mem_write  input  1 each  load / store request (mutually exclusive)
- in_rd  input  5  destination register, passed through
- in_mem_to_reg, in_write_enable  input  1 each  WB control, passed through (write enable gated)
- out_mem_req  output  1  bus request, held until ready
- out_mem_we  output  1  1 = store
- out_mem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- out_mem_wdata  output  32  store data shifted to its byte lanes
- out_mem_wstrb  output  4  byte-lane strobes (0 on loads)
- in_mem_ready  input  1  bus completion, one cycle
- in_mem_rdata  input  32  full read word, valid with ready
- out_stall  output  1  hold IF/ID/EX/EX-MEM registers this cycle
- out_read_data  output  32  extended load data
- out_alu_out, out_rd, out_mem_to_reg  output  32/5/1  passthrough
- out_write_enable  output  1  in_write_enable AND NOT out_exception
- out_exception  output  1  misaligned access or bus timeout
- out_exc_cause  output  2  01 misaligned load, 10 misaligned store, 11 timeout

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: no access → out_stall=0, outputs pass through, out_read_data=0.
- IDLE with access:
  - Misaligned (H with addr[0]=1; W with addr[1:0]≠0): out_stall=0, out_exception=1, cause set, no bus request, stay IDLE.
  - Aligned: out_stall=1 combinationally. Latch addr, lane-shifted wdata, wstrb, we, funct3 and addr[1:0]; clear timeout counter; go to BUSY.
- Strobes:
  - SB: 0001 shifted by addr[1:0].
  - SH: 0011 (addr[1]=0) or 1100.
  - SW: 1111.
  - wdata is the byte/half replicated to every lane.
- BUSY: out_mem_req=1 with latched fields stable; out_stall=1; counter increments each cycle.
  - in_mem_ready: capture extended rdata into the data register; go to DONE.
  - Counter reaches TIMEOUT (nonzero): drop the request; out_exception=1, cause 11; go to DONE.
- Load extension: select lane by latched addr[1:0].
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W unchanged.
- DONE: out_stall=0, out_read_data=data register (0 on timeout), exception flags held for this cycle only; return to IDLE. The pipeline advances at the end of DONE.
- Stores take the same path; out_read_data=0.

## Timing
- Reset (async): state IDLE, out_mem_req=0, out_mem_we=0, out_mem_wstrb=0, out_mem_addr=0, out_mem_wdata=0, out_read_data=0, out_exception=0, out_exc_cause=0, counter 0. A transaction in flight is abandoned; the memory side must tolerate a dropped request.
- Non-memory instruction: 0 stall cycles.
- Access with ready in the k-th BUSY cycle (k≥1): stall k+1 cycles; data on out_read_data in the DONE cycle.
- Minimum latency: IDLE → BUSY → DONE, so 2 stall cycles.
- Inputs must stay stable while out_stall=1; the block relies on its latched copies only in BUSY.
- in_mem_ready outside BUSY is ignored.
- Ready arriving in the same cycle the counter hits TIMEOUT: ready wins, no exception.
- Timeout: the counter counts BUSY cycles; the request drops after TIMEOUT cycles.
- Back-to-back accesses: DONE of access 1 is followed by IDLE accepting access 2; no bubble beyond the FSM.

## Test plan
- LW addr 0x100, ready in 1st BUSY cycle, rdata 0xDEADBEEF → stall 2 cycles, DONE out_read_data=0xDEADBEEF, wstrb 0000, mem_addr 0x100.
- LB addr 0x103 rdata 0x80FF_0000 → 0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x000080FF.
- SB addr 0x201 data 0x000000AB → mem_addr 0x200, wstrb 0010, wdata 0xABABABAB, we=1; SH addr 0x202 data 0x1234 → wstrb 1100.
- LW addr 0x102 → no req, out_exception=1, cause 01, out_write_enable=0, no stall; SH addr 0x301 → cause 10.
- TIMEOUT=4, ready never asserted → req high 4 cycles then dropped, DONE with cause 11, out_read_data=0; separate case: ready on cycle 4 → normal completion, no exception.
- Reset asserted mid-BUSY → out_mem_req drops immediately (async), state IDLE; next LW completes normally.
